// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back data cache controller
module dcache_ctrl #(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int TAG_W       = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int LINE_W = BLOCK_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t                state;
  logic [LINE_W-1:0]     line_q [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [LINE_W-1:0]     fill_q;

  logic [TAG_W-1:0]      tag;
  logic [IDX_W-1:0]      idx;
  logic [OFF_W-1:0]      off;
  logic                  req;
  logic                  hit;
  logic                  victim_dirty;

  // Address split: tag | index | byte offset
  assign tag = ADDRESS[7 -: TAG_W];
  assign idx = ADDRESS[OFF_W +: IDX_W];
  assign off = ADDRESS[OFF_W-1:0];

  // A request with both strobes high is handled as a store
  assign req          = READ | WRITE;
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  // Stall whenever a miss is being serviced or a new request misses
  assign BUSYWAIT = !RESET && ((state != IDLE) || (req && !hit));

  // Load data comes straight from the array so a hit costs no cycle
  assign READDATA = RESET ? 8'h00 : line_q[idx][{off, 3'b000} +: 8];

  // Miss-handling FSM, store-hit commit and fill of the line arrays
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      valid_q       <= '0;
      dirty_q       <= '0;
      fill_q        <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (WRITE) begin
                line_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
                dirty_q[idx]                    <= 1'b1;
              end
            end else if (victim_dirty) begin
              state         <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {tag_q[idx], idx};
              MEM_WRITEDATA <= line_q[idx];
            end else begin
              state       <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {tag, idx};
            end
          end
        end

        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state         <= FETCH;
            MEM_WRITE     <= 1'b0;
            MEM_WRITEDATA <= '0;
            MEM_READ      <= 1'b1;
            MEM_ADDRESS   <= {tag, idx};
          end
        end

        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state       <= UPDATE;
            MEM_READ    <= 1'b0;
            MEM_ADDRESS <= '0;
            fill_q      <= MEM_READDATA;
          end
        end

        UPDATE: begin
          line_q[idx]  <= fill_q;
          tag_q[idx]   <= tag;
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl
module tb_dcache_ctrl;

  localparam int L = 5;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  dcache_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Initial contents of the backing store
  function automatic logic [31:0] init_val(logic [5:0] a);
    logic [31:0] x;
    x = ({26'd0, a} * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    if (a == 6'h09) x = 32'hDDCCBBAA;
    return x;
  endfunction

  // Data memory device: a fresh request is ready in its L-th cycle,
  // a request following straight on a completed one needs one more
  logic [31:0] mem_w [64];
  bit          mem_written [64];
  int          mcnt;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt != L - 1);
  assign MEM_READDATA = mem_written[MEM_ADDRESS] ? mem_w[MEM_ADDRESS] : init_val(MEM_ADDRESS);

  always @(posedge CLK) begin
    if (RESET || !(MEM_READ || MEM_WRITE)) mcnt <= 0;
    else if (mcnt == L - 1) begin
      if (MEM_WRITE) begin
        mem_w[MEM_ADDRESS]       <= MEM_WRITEDATA;
        mem_written[MEM_ADDRESS] <= 1'b1;
      end
      mcnt <= -1;
    end else mcnt <= mcnt + 1;
  end

  // Reference model: cache contents plus its own view of memory
  bit          rvalid [8];
  bit          rdirty [8];
  logic [2:0]  rtag   [8];
  logic [31:0] rline  [8];
  logic [31:0] rmem   [64];
  bit          rmem_written [64];

  typedef struct {
    bit          is_wr;
    logic [7:0]  exp_rd;
    int          exp_stall;
    bit          exp_wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    bit          exp_fetch;
    logic [5:0]  f_addr;
  } exp_t;

  exp_t q[$];
  bit   mon_en = 1'b0;

  task automatic model(input bit rd, input bit wr, input logic [7:0] a,
                       input logic [7:0] d, output exp_t e);
    int i, o;
    logic [2:0] t;
    logic [5:0] blk;
    i = int'(a[4:2]);
    o = int'(a[1:0]);
    t = a[7:5];
    e = '{default: 0};
    e.is_wr = wr;
    if (!(rvalid[i] && rtag[i] == t)) begin
      if (rvalid[i] && rdirty[i]) begin
        e.exp_wb  = 1'b1;
        e.wb_addr = {rtag[i], a[4:2]};
        e.wb_data = rline[i];
        rmem[e.wb_addr]         = rline[i];
        rmem_written[e.wb_addr] = 1'b1;
        e.exp_stall = 2 * L + 3;
      end else begin
        e.exp_stall = L + 2;
      end
      blk         = {t, a[4:2]};
      e.exp_fetch = 1'b1;
      e.f_addr    = blk;
      rline[i]    = rmem_written[blk] ? rmem[blk] : init_val(blk);
      rtag[i]     = t;
      rvalid[i]   = 1'b1;
      rdirty[i]   = 1'b0;
    end
    if (wr) begin
      rline[i][o*8 +: 8] = d;
      rdirty[i] = 1'b1;
    end else if (rd) begin
      e.exp_rd = rline[i][o*8 +: 8];
    end
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int n;
    model(rd, wr, a, d, e);
    q.push_back(e);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (BUSYWAIT && n < 100);
    chk("stall_bound", {31'd0, BUSYWAIT}, 32'd0);
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  // Monitor: accumulates each access and checks it when the stall lifts
  initial begin
    int          stall;
    bit          saw_wb, saw_f;
    logic [5:0]  wa, fa;
    logic [31:0] wd;
    exp_t        e;
    stall = 0; saw_wb = 0; saw_f = 0; wa = '0; fa = '0; wd = '0;
    forever begin
      @(negedge CLK);
      if (mon_en && !RESET && (READ || WRITE)) begin
        if (MEM_WRITE) begin saw_wb = 1; wa = MEM_ADDRESS; wd = MEM_WRITEDATA; end
        if (MEM_READ)  begin saw_f = 1;  fa = MEM_ADDRESS; end
        if (BUSYWAIT) stall++;
        else begin
          if (q.size() == 0) chk("unexpected_access", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            chk("stall_cycles", stall, e.exp_stall);
            if (!e.is_wr) chk("readdata", {24'd0, READDATA}, {24'd0, e.exp_rd});
            chk("writeback_seen", {31'd0, saw_wb}, {31'd0, e.exp_wb});
            if (e.exp_wb) begin
              chk("wb_addr", {26'd0, wa}, {26'd0, e.wb_addr});
              chk("wb_data", wd, e.wb_data);
            end
            chk("fetch_seen", {31'd0, saw_f}, {31'd0, e.exp_fetch});
            if (e.exp_fetch) chk("fetch_addr", {26'd0, fa}, {26'd0, e.f_addr});
          end
          stall = 0; saw_wb = 0; saw_f = 0;
        end
      end else if (!mon_en || RESET) begin
        stall = 0; saw_wb = 0; saw_f = 0;
      end
    end
  end

  // Stimulus: reset, directed sequence, reset during a fill, random traffic
  initial begin
    logic [2:0] t, ix;
    logic [1:0] of;
    int         k;
    for (int i = 0; i < 64; i++) rmem_written[i] = 1'b0;
    for (int i = 0; i < 8; i++) begin rvalid[i] = 0; rdirty[i] = 0; rtag[i] = '0; rline[i] = '0; end
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h24; WRITEDATA = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_readdata", {24'd0, READDATA}, 32'd0);
    chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
    chk("rst_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
    chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0;
    mon_en = 1'b1;

    issue(1, 0, 8'h24, 8'h00);
    issue(1, 0, 8'h27, 8'h00);
    issue(0, 1, 8'h25, 8'h5A);
    issue(1, 0, 8'h25, 8'h00);
    issue(1, 0, 8'hA4, 8'h00);
    issue(1, 1, 8'hA5, 8'h11);
    issue(1, 0, 8'hA5, 8'h00);
    issue(0, 1, 8'h10, 8'h77);
    issue(1, 0, 8'h10, 8'h00);

    // Reset arriving in the second fetch cycle abandons the fill
    mon_en = 1'b0;
    READ = 1'b1; ADDRESS = 8'h58;
    @(posedge CLK);
    @(negedge CLK);
    chk("fill_started", {31'd0, MEM_READ}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk("midfill_rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0;
    @(negedge CLK);
    chk("post_rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("post_rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    for (int i = 0; i < 8; i++) begin rvalid[i] = 0; rdirty[i] = 0; end
    @(posedge CLK); #1;
    mon_en = 1'b1;
    issue(1, 0, 8'h58, 8'h00);
    issue(1, 0, 8'h24, 8'h00);

    for (int n = 0; n < 250; n++) begin
      t  = 3'($urandom_range(0, 3));
      ix = 3'($urandom_range(0, 7));
      of = 2'($urandom_range(0, 3));
      k  = $urandom_range(0, 9);
      if (k < 5)      issue(1, 0, {t, ix, of}, 8'h00);
      else if (k < 9) issue(0, 1, {t, ix, of}, 8'($urandom));
      else            issue(1, 1, {t, ix, of}, 8'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end

    repeat (2) @(posedge CLK);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
